// File: rtl/adam_fabric_pkg.sv
// Shared types for the LSDOM fabric pause sequencer: FSM state encoding and
// a sizing helper for the DRAIN timer.
package adam_fabric_pkg;

  typedef enum logic [3:0] {
    ST_RUN,
    ST_P_INIT,
    ST_DRAIN,
    ST_P_FAB,
    ST_P_TGT,
    ST_PAUSED,
    ST_R_TGT,
    ST_R_FAB,
    ST_R_INIT
  } PAUSE_SEQ_STATE_T;

  // Timer only has to reach TIMEOUT-1, but is never narrower than one bit.
  function automatic int timer_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/adam_fabric_txn_counter.sv
// Outstanding AXI-Lite transaction counter across all monitored fabric slave
// ports, with clamp-on-underflow, saturate-on-overflow and a sticky error flag.
module adam_fabric_txn_counter #(
  parameter int NO_INIT = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NO_INIT-1:0] aw_hs,
  input  logic [NO_INIT-1:0] ar_hs,
  input  logic [NO_INIT-1:0] b_hs,
  input  logic [NO_INIT-1:0] r_hs,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   cnt,
  output logic               cnt_err
);

  // Two guard bits: one for the sign, one for headroom above the counter range.
  localparam int SUM_W = CNT_W + 2;
  localparam logic signed [SUM_W-1:0] CNT_MAX = $signed({2'b00, {CNT_W{1'b1}}});

  function automatic logic signed [SUM_W-1:0] popcnt(input logic [NO_INIT-1:0] v);
    logic signed [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < NO_INIT; i++) begin
      n = n + $signed({{(SUM_W-1){1'b0}}, v[i]});
    end
    return n;
  endfunction

  function automatic logic out_of_range(input logic signed [SUM_W-1:0] v);
    return v[SUM_W-1] || (v > CNT_MAX);
  endfunction

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1]) begin
      return '0;
    end else if (v > CNT_MAX) begin
      return '1;
    end else begin
      return v[CNT_W-1:0];
    end
  endfunction

  logic signed [SUM_W-1:0] sum;

  always_comb begin
    sum = $signed({2'b00, cnt}) + popcnt(aw_hs) + popcnt(ar_hs)
          - popcnt(b_hs) - popcnt(r_hs);
  end

  // A fresh error in the clearing cycle wins so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      cnt_err <= 1'b0;
    end else begin
      cnt     <= clamp_cnt(sum);
      cnt_err <= out_of_range(sum) | (cnt_err & ~err_clr);
    end
  end

endmodule

// File: rtl/adam_fabric_pause_seq.sv
// Pause/resume sequencer for the LSDOM AXI-Lite fabric: initiators, drain,
// crossbar, targets on pause; exact reverse order on resume.
module adam_fabric_pause_seq
  import adam_fabric_pkg::*;
#(
  parameter int NO_INIT = 3,
  parameter int NO_TGT  = 5,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause_req,
  output logic               pause_ack,
  output logic [NO_INIT-1:0] init_req,
  input  logic [NO_INIT-1:0] init_ack,
  output logic               fab_req,
  input  logic               fab_ack,
  output logic [NO_TGT-1:0]  tgt_req,
  input  logic [NO_TGT-1:0]  tgt_ack,
  input  logic [NO_INIT-1:0] aw_hs,
  input  logic [NO_INIT-1:0] ar_hs,
  input  logic [NO_INIT-1:0] b_hs,
  input  logic [NO_INIT-1:0] r_hs,
  output logic [CNT_W-1:0]   outstanding,
  output logic               timeout_err,
  output logic               cnt_err
);

  localparam int TMR_W = timer_width(TIMEOUT);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);

  PAUSE_SEQ_STATE_T   state, state_nxt;
  logic [NO_INIT-1:0] init_req_nxt;
  logic               fab_req_nxt;
  logic [NO_TGT-1:0]  tgt_req_nxt;
  logic               pause_ack_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               timeout_err_nxt;
  logic               seq_start;

  assign seq_start = (state == ST_RUN) && pause_req;

  adam_fabric_txn_counter #(
    .NO_INIT (NO_INIT),
    .CNT_W   (CNT_W)
  ) u_txn_counter (
    .clk     (clk),
    .rst     (rst),
    .aw_hs   (aw_hs),
    .ar_hs   (ar_hs),
    .b_hs    (b_hs),
    .r_hs    (r_hs),
    .err_clr (seq_start),
    .cnt     (outstanding),
    .cnt_err (cnt_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      init_req    <= '0;
      fab_req     <= 1'b0;
      tgt_req     <= '0;
      pause_ack   <= 1'b0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      init_req    <= init_req_nxt;
      fab_req     <= fab_req_nxt;
      tgt_req     <= tgt_req_nxt;
      pause_ack   <= pause_ack_nxt;
      timer       <= timer_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  // Every req edge happens only while that req still matches its ack, which
  // keeps each channel a clean 4-phase handshake.
  always_comb begin
    state_nxt       = state;
    init_req_nxt    = init_req;
    fab_req_nxt     = fab_req;
    tgt_req_nxt     = tgt_req;
    pause_ack_nxt   = pause_ack;
    timer_nxt       = timer;
    timeout_err_nxt = timeout_err;
    unique case (state)
      ST_RUN: begin
        if (pause_req) begin
          state_nxt       = ST_P_INIT;
          init_req_nxt    = '1;
          timeout_err_nxt = 1'b0;
        end
      end
      ST_P_INIT: begin
        if (&init_ack) begin
          state_nxt = ST_DRAIN;
          timer_nxt = '0;
        end
      end
      ST_DRAIN: begin
        timer_nxt = timer + 1'b1;
        if (outstanding == '0) begin
          state_nxt   = ST_P_FAB;
          fab_req_nxt = 1'b1;
        end else if (timer == TIMER_LAST) begin
          state_nxt       = ST_P_FAB;
          fab_req_nxt     = 1'b1;
          timeout_err_nxt = 1'b1;
        end
      end
      ST_P_FAB: begin
        if (fab_ack) begin
          state_nxt   = ST_P_TGT;
          tgt_req_nxt = '1;
        end
      end
      ST_P_TGT: begin
        if (&tgt_ack) begin
          state_nxt     = ST_PAUSED;
          pause_ack_nxt = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (!pause_req) begin
          state_nxt   = ST_R_TGT;
          tgt_req_nxt = '0;
        end
      end
      ST_R_TGT: begin
        if (~|tgt_ack) begin
          state_nxt   = ST_R_FAB;
          fab_req_nxt = 1'b0;
        end
      end
      ST_R_FAB: begin
        if (!fab_ack) begin
          state_nxt    = ST_R_INIT;
          init_req_nxt = '0;
        end
      end
      ST_R_INIT: begin
        if (~|init_ack) begin
          state_nxt     = ST_RUN;
          pause_ack_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

endmodule
